// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, MD_BUSY} state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MULDIV_LAT_DEF = 4;
endpackage

// File: rtl/muldiv_timer.sv
// Loadable down-counter that times the mul/div unit; it parks at zero.
module muldiv_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)           cnt <= '0;
        else if (load)        cnt <= value;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mul/div freeze.
// Optional HAZARD_PERF_EN adds a saturating stall-cycle counter (stall_cnt_o).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  rsaddr_i,
    input  logic [4:0]  rtaddr_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rtaddr_i,
    input  logic        idex_muldiv_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_write_o,
    output logic        idex_bubble_o,
    output logic        exmem_bubble_o,
    output logic        muldiv_start_o,
    output logic        muldiv_done_o,
    output logic        busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam int          CW       = $clog2(MULDIV_LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MULDIV_LAT - 1);

    state_e state;
    logic   cnt_zero;
    logic   cnt_load;
    logic   load_use;

    assign load_use = idex_memread_i && (idex_rtaddr_i != REG_ZERO) &&
                      ((idex_rtaddr_i == rsaddr_i) || (idex_rtaddr_i == rtaddr_i));
    assign cnt_load = (state == RUN) && idex_muldiv_i;

    muldiv_timer #(.W(CW)) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (cnt_load),
        .value (LOAD_VAL),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i)       state <= RUN;
                RUN:     if (idex_muldiv_i) state <= MD_BUSY;
                MD_BUSY: if (cnt_zero)      state <= RUN;
                default:                    state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        muldiv_start_o = 1'b0;
        muldiv_done_o  = 1'b0;
        busy_o         = (state == MD_BUSY);
        case (state)
            RUN: begin
                if (idex_muldiv_i) begin
                    muldiv_start_o = 1'b1;
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_write_o   = 1'b0;
                    exmem_bubble_o = 1'b1;
                end else if (load_use) begin
                    // branch flush is held off so it re-resolves after the stall
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                end
            end
            MD_BUSY: begin
                if (cnt_zero) begin
                    muldiv_done_o = 1'b1;
                end else begin
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_write_o   = 1'b0;
                    exmem_bubble_o = 1'b1;
                end
            end
            default: begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if ((state != IDLE) && !pc_write_o && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed output vectors.
module tb_hazard_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [4:0] rsaddr_i, rtaddr_i, idex_rtaddr_i;
    logic       idex_memread_i, idex_muldiv_i, branch_taken_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o;
    logic       exmem_bubble_o, muldiv_start_o, muldiv_done_o, busy_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    // {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_bub, md_start, md_done, busy}
    localparam logic [8:0] V_IDLE  = 9'b000010000;
    localparam logic [8:0] V_RUN   = 9'b110100000;
    localparam logic [8:0] V_LU    = 9'b000110000;
    localparam logic [8:0] V_BR    = 9'b111100000;
    localparam logic [8:0] V_MDST  = 9'b000001100;
    localparam logic [8:0] V_MDH   = 9'b000001001;
    localparam logic [8:0] V_MDDN  = 9'b110100011;

    logic [8:0] ov;
    assign ov = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
                 exmem_bubble_o, muldiv_start_o, muldiv_done_o, busy_o};

    hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .rsaddr_i       (rsaddr_i),
        .rtaddr_i       (rtaddr_i),
        .idex_memread_i (idex_memread_i),
        .idex_rtaddr_i  (idex_rtaddr_i),
        .idex_muldiv_i  (idex_muldiv_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_write_o   (idex_write_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_bubble_o (exmem_bubble_o),
        .muldiv_start_o (muldiv_start_o),
        .muldiv_done_o  (muldiv_done_o),
        .busy_o         (busy_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic md, input logic mrd, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic br);
        idex_muldiv_i  = md;
        idex_memread_i = mrd;
        idex_rtaddr_i  = xrt;
        rsaddr_i       = rs;
        rtaddr_i       = rt;
        branch_taken_i = br;
        #1;
    endtask

    // Assumes idex_muldiv_i=1 is already applied in RUN; ends in the done cycle.
    task automatic md_op(input string tag);
        chk({tag, "_start"}, 32'(ov), 32'(V_MDST));
        for (int i = 1; i <= 3; i++) begin
            step();
            drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1);   // hazard + branch must be ignored
            chk($sformatf("%s_hold%0d", tag, i), 32'(ov), 32'(V_MDH));
        end
        step();
        chk({tag, "_done"}, 32'(ov), 32'(V_MDDN));
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("reset_idle", 32'(ov), 32'(V_IDLE));
        step(); step();
        rst_i = 1'b1;
        step();
        chk("idle_no_start", 32'(ov), 32'(V_IDLE));
        start_i = 1'b1;
        #1;
        chk("idle_start_same_cycle", 32'(ov), 32'(V_IDLE));
        step();
        start_i = 1'b0;
        #1;
        chk("run_after_start", 32'(ov), 32'(V_RUN));

        // load-use on rs, then on rt, then reg0 and a mismatch that must not stall
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0);
        chk("lu_rs", 32'(ov), 32'(V_LU));
        step();
        drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd9, 1'b0);
        chk("lu_one_cycle", 32'(ov), 32'(V_RUN));
        drive(1'b0, 1'b1, 5'd12, 5'd3, 5'd12, 1'b0);
        chk("lu_rt", 32'(ov), 32'(V_LU));
        step();
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lu_reg0", 32'(ov), 32'(V_RUN));
        drive(1'b0, 1'b1, 5'd6, 5'd5, 5'd7, 1'b0);
        chk("lu_mismatch", 32'(ov), 32'(V_RUN));
        drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0);
        chk("no_memread", 32'(ov), 32'(V_RUN));

        // load-use beats branch, branch flushes the following cycle
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b1);
        chk("lu_over_branch", 32'(ov), 32'(V_LU));
        step();
        drive(1'b0, 1'b0, 5'd8, 5'd8, 5'd1, 1'b1);
        chk("branch_flush", 32'(ov), 32'(V_BR));
        step();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // mul/div, then a back-to-back op which is killed by reset mid-busy
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        md_op("md1");
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("md2_start", 32'(ov), 32'(V_MDST));
        step();
        chk("md2_hold1", 32'(ov), 32'(V_MDH));
        step();
        chk("md2_hold2", 32'(ov), 32'(V_MDH));
        rst_i = 1'b0;
        #1;
        chk("md2_reset_idle", 32'(ov), 32'(V_IDLE));
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("md2_no_done%0d", i), 32'(muldiv_done_o), 32'd0);
        end
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("post_reset_idle", 32'(ov), 32'(V_IDLE));

        // restart: one load-use stall plus one mul/div op
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        drive(1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0);
        chk("restart_lu", 32'(ov), 32'(V_LU));
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        md_op("md3");
        step();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("md3_release", 32'(ov), 32'(V_RUN));
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt_o, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
